cpu_wb_bridge: RTL and testbench

// - Downstream of the 68040 bus interface: takes its request/write/read streams and runs

---
 rtl/cpubus_pkg.sv | 13 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/cpu_wb_bridge.sv | 131 +++++++++++++
 tb/tb_cpu_wb_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpubus_pkg.sv
// Shared constants and types for the CPU-side to Wishbone bridge.
package cpubus_pkg;

    localparam logic [2:0]  LEN_SINGLE  = 3'd1;
    localparam logic [2:0]  LEN_LINE    = 3'd4;
    localparam logic [31:0] WB_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE,
        ST_BEAT
    } bridge_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a fill counter.
// Writes are dropped when full and reads are ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cpu_wb_bridge.sv
// Runs Wishbone B4 classic single/line cycles on behalf of the CPU bus interface,
// buffering write and read data; errors and silent slaves terminate with all-ones data.
module cpu_wb_bridge
    import cpubus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_len_i,
    input  logic [3:0]  req_mask_i,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic        write_valid_i,
    input  logic [31:0] write_data_i,
    output logic        read_valid_o,
    output logic [31:0] read_data_o,
    input  logic        read_ack_i,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    bridge_state_t state, state_nxt;
    logic          line_q;
    logic [1:0]    beat_q;
    logic [TW-1:0] tmo_q;
    logic          accept, term, tmo_hit, beat_err, last_beat;
    logic          wf_full, wf_empty, rf_full, rf_empty;
    logic [31:0]   rf_push_data;

    assign req_ready_o = (state == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;

    // Reads stall while the read buffer is full; writes stall until data is buffered.
    assign wb_stb_o  = (state == ST_BEAT) && (wb_we_o ? !wf_empty : !rf_full);
    assign tmo_hit   = wb_stb_o && (tmo_q == TW'(TIMEOUT - 1));
    assign term      = wb_stb_o & (wb_ack_i | wb_err_i | tmo_hit);
    assign beat_err  = wb_err_i | ~wb_ack_i;
    assign last_beat = (beat_q == (line_q ? 2'd3 : 2'd0));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)            state_nxt = ST_BEAT;
            ST_BEAT: if (term && last_beat) state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= '0;
            line_q    <= 1'b0;
            beat_q    <= '0;
            tmo_q     <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= (term & beat_err) | (write_valid_i & wf_full);
            if (accept) begin
                wb_cyc_o <= 1'b1;
                wb_we_o  <= req_we_i;
                wb_adr_o <= req_addr_i;
                wb_sel_o <= req_mask_i;
                line_q   <= (req_len_i == LEN_LINE);
                beat_q   <= '0;
                tmo_q    <= '0;
            end else if (term) begin
                tmo_q <= '0;
                if (last_beat) begin
                    wb_cyc_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                end else begin
                    // Line bursts wrap inside the 16-byte line.
                    beat_q   <= beat_q + 2'd1;
                    wb_adr_o <= {wb_adr_o[31:4], wb_adr_o[3:2] + 2'd1, 2'b00};
                    wb_sel_o <= 4'b1111;
                end
            end else if (wb_stb_o) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign rf_push_data = beat_err ? WB_ERR_DATA : wb_dat_i;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (write_valid_i),
        .push_data (write_data_i),
        .pop       (term & wb_we_o),
        .head      (wb_dat_o),
        .full      (wf_full),
        .empty     (wf_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (term & ~wb_we_o),
        .push_data (rf_push_data),
        .pop       (read_ack_i),
        .head      (read_data_o),
        .full      (rf_full),
        .empty     (rf_empty)
    );

    assign read_valid_o = ~rf_empty;

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Directed bench for cpu_wb_bridge: single/line reads and writes, stalls, errors,
// timeout, dropped writes and mid-burst reset.
module tb_cpu_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_len_i = 3'd1;
    logic [3:0]  req_mask_i = 4'h0;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic        write_valid_i = 1'b0;
    logic [31:0] write_data_i = '0;
    logic        read_valid_o;
    logic [31:0] read_data_o;
    logic        read_ack_i = 1'b0;
    logic        bus_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int errors = 0;
    int checks = 0;

    cpu_wb_bridge #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_len_i     (req_len_i),
        .req_mask_i    (req_mask_i),
        .req_addr_i    (req_addr_i),
        .req_we_i      (req_we_i),
        .write_valid_i (write_valid_i),
        .write_data_i  (write_data_i),
        .read_valid_o  (read_valid_o),
        .read_data_o   (read_data_o),
        .read_ack_i    (read_ack_i),
        .bus_err_o     (bus_err_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_sel_o      (wb_sel_o),
        .wb_dat_o      (wb_dat_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (!wb_stb_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, " stb"}, 32'(wb_stb_o), 32'd1);
    endtask

    task automatic request(input logic [31:0] addr, input logic [2:0] len,
                           input logic [3:0] mask, input logic we);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_len_i   = len;
        req_mask_i  = mask;
        req_we_i    = we;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic slave_ack(input logic [31:0] data, input logic ack, input logic err);
        wb_dat_i = data;
        wb_ack_i = ack;
        wb_err_i = err;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check({tag, " valid"}, 32'(read_valid_o), 32'd1);
        check({tag, " data"}, read_data_o, exp);
        read_ack_i = 1'b1;
        tick();
        read_ack_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_adr [4];
        int n;

        // Reset state
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check("rst ready", 32'(req_ready_o), 32'd1);
        check("rst cyc",   32'(wb_cyc_o), 32'd0);
        check("rst stb",   32'(wb_stb_o), 32'd0);
        check("rst we",    32'(wb_we_o), 32'd0);
        check("rst adr",   wb_adr_o, 32'h0);
        check("rst sel",   32'(wb_sel_o), 32'h0);
        check("rst rvld",  32'(read_valid_o), 32'd0);
        check("rst berr",  32'(bus_err_o), 32'd0);

        // Single read, slave acks after 2 cycles; entry left buffered for the next test
        request(32'h0000_1004, 3'd1, 4'hF, 1'b0);
        check("rd1 cyc",   32'(wb_cyc_o), 32'd1);
        check("rd1 stb",   32'(wb_stb_o), 32'd1);
        check("rd1 we",    32'(wb_we_o), 32'd0);
        check("rd1 adr",   wb_adr_o, 32'h0000_1004);
        check("rd1 sel",   32'(wb_sel_o), 32'hF);
        check("rd1 ready", 32'(req_ready_o), 32'd0);
        tick();
        tick();
        slave_ack(32'hDEAD_BEEF, 1'b1, 1'b0);
        check("rd1 end cyc", 32'(wb_cyc_o), 32'd0);
        check("rd1 end stb", 32'(wb_stb_o), 32'd0);
        check("rd1 rvld",    32'(read_valid_o), 32'd1);
        check("rd1 rdata",   read_data_o, 32'hDEAD_BEEF);
        check("rd1 ready2",  32'(req_ready_o), 32'd1);
        check("rd1 berr",    32'(bus_err_o), 32'd0);

        // Line read with wrap; buffer fills after 3 beats and stalls stb
        exp_adr = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
        request(32'h0000_2008, 3'd4, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_stb($sformatf("line rd %0d", i));
            check($sformatf("line rd adr %0d", i), wb_adr_o, exp_adr[i]);
            check($sformatf("line rd sel %0d", i), 32'(wb_sel_o), 32'hF);
            slave_ack(32'h1111_0000 + 32'(i), 1'b1, 1'b0);
        end
        check("stall stb", 32'(wb_stb_o), 32'd0);
        check("stall cyc", 32'(wb_cyc_o), 32'd1);
        slave_ack(32'h1234_5678, 1'b1, 1'b0);
        check("ign ack stb",  32'(wb_stb_o), 32'd0);
        check("ign ack cyc",  32'(wb_cyc_o), 32'd1);
        check("ign ack head", read_data_o, 32'hDEAD_BEEF);
        pop_expect("pop rd1", 32'hDEAD_BEEF);
        wait_stb("line rd 3");
        check("line rd adr 3", wb_adr_o, exp_adr[3]);
        slave_ack(32'h1111_0003, 1'b1, 1'b0);
        check("line rd end cyc",   32'(wb_cyc_o), 32'd0);
        check("line rd end ready", 32'(req_ready_o), 32'd1);
        for (int i = 0; i < 4; i++)
            pop_expect($sformatf("pop line %0d", i), 32'h1111_0000 + 32'(i));
        check("line rd drained", 32'(read_valid_o), 32'd0);

        // Byte write, data arrives 3 cycles after accept
        request(32'h0000_3003, 3'd1, 4'b0001, 1'b1);
        check("bw cyc", 32'(wb_cyc_o), 32'd1);
        check("bw we",  32'(wb_we_o), 32'd1);
        check("bw stb nodata", 32'(wb_stb_o), 32'd0);
        tick();
        tick();
        check("bw stb still", 32'(wb_stb_o), 32'd0);
        write_valid_i = 1'b1;
        write_data_i  = 32'h0000_00AA;
        tick();
        write_valid_i = 1'b0;
        check("bw stb", 32'(wb_stb_o), 32'd1);
        check("bw adr", wb_adr_o, 32'h0000_3003);
        check("bw sel", 32'(wb_sel_o), 32'b0001);
        check("bw dat", wb_dat_o, 32'h0000_00AA);
        slave_ack(32'h0, 1'b1, 1'b0);
        check("bw end cyc", 32'(wb_cyc_o), 32'd0);
        check("bw berr",    32'(bus_err_o), 32'd0);

        // Line write, 4 back-to-back data strobes, 5-cycle slave acks
        exp_adr = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
        write_valid_i = 1'b1;
        write_data_i  = 32'hA000_0000;
        request(32'h0000_4000, 3'd4, 4'hF, 1'b1);
        for (int i = 1; i < 4; i++) begin
            write_data_i = 32'hA000_0000 + 32'(i);
            tick();
        end
        write_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_stb($sformatf("line wr %0d", i));
            check($sformatf("line wr adr %0d", i), wb_adr_o, exp_adr[i]);
            check($sformatf("line wr dat %0d", i), wb_dat_o, 32'hA000_0000 + 32'(i));
            check($sformatf("line wr we %0d", i), 32'(wb_we_o), 32'd1);
            for (int k = 0; k < 4; k++) tick();
            slave_ack(32'h0, 1'b1, 1'b0);
            check($sformatf("line wr berr %0d", i), 32'(bus_err_o), 32'd0);
        end
        check("line wr end cyc", 32'(wb_cyc_o), 32'd0);
        check("line wr end stb", 32'(wb_stb_o), 32'd0);

        // Read terminated by err, then by ack+err together
        request(32'h0000_5000, 3'd1, 4'hF, 1'b0);
        wait_stb("err rd");
        slave_ack(32'h1357_9BDF, 1'b0, 1'b1);
        check("err rd berr", 32'(bus_err_o), 32'd1);
        check("err rd cyc",  32'(wb_cyc_o), 32'd0);
        tick();
        check("err rd berr pulse", 32'(bus_err_o), 32'd0);
        pop_expect("err rd", 32'hFFFF_FFFF);
        request(32'h0000_5004, 3'd1, 4'hF, 1'b0);
        wait_stb("ackerr rd");
        slave_ack(32'h2468_ACE0, 1'b1, 1'b1);
        check("ackerr berr", 32'(bus_err_o), 32'd1);
        pop_expect("ackerr rd", 32'hFFFF_FFFF);

        // Silent slave: terminates after 255 stb-high cycles
        request(32'h0000_6000, 3'd1, 4'hF, 1'b0);
        check("tmo stb", 32'(wb_stb_o), 32'd1);
        n = 0;
        while (wb_cyc_o && n < 400) begin
            tick();
            n++;
        end
        check("tmo cycles", 32'(n), 32'd255);
        check("tmo berr",   32'(bus_err_o), 32'd1);
        pop_expect("tmo rd", 32'hFFFF_FFFF);

        // Write buffer overflow while idle: 5th strobe dropped with an error pulse
        write_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_data_i = 32'hB000_0000 + 32'(i);
            tick();
        end
        check("ovf no berr", 32'(bus_err_o), 32'd0);
        tick();
        write_valid_i = 1'b0;
        check("ovf berr", 32'(bus_err_o), 32'd1);
        tick();
        check("ovf berr pulse", 32'(bus_err_o), 32'd0);

        // Reset in the middle of a line read
        request(32'h0000_7000, 3'd4, 4'hF, 1'b0);
        wait_stb("rst burst");
        slave_ack(32'hCAFE_0000, 1'b1, 1'b0);
        check("pre rst rvld", 32'(read_valid_o), 32'd1);
        check("pre rst cyc",  32'(wb_cyc_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        check("mid rst cyc",  32'(wb_cyc_o), 32'd0);
        check("mid rst stb",  32'(wb_stb_o), 32'd0);
        check("mid rst rvld", 32'(read_valid_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        check("post rst ready", 32'(req_ready_o), 32'd1);
        // Stale overflow data must have been flushed: write waits for fresh data
        request(32'h0000_8000, 3'd1, 4'hF, 1'b1);
        check("post rst wr cyc", 32'(wb_cyc_o), 32'd1);
        check("post rst wr stb", 32'(wb_stb_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
